// File: rtl/bloc_pipe.sv
// bloc_pipe: XOR-family bitwise operation on two operands, carried through
// STAGES elastic valid/ready register stages that absorb downstream backpressure.
module bloc_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_c,
   output logic             out_parity,
   output logic [15:0]      xfer_count
);

   function automatic logic even_parity(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction

   // Result is packed as {parity, c}.
   function automatic logic [WIDTH:0] apply_op(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [1:0]       mode);
      logic [WIDTH-1:0] x;
      x = a ^ b;
      case (mode)
         2'b00:   apply_op = {1'b0, x};
         2'b01:   apply_op = {1'b0, ~x};
         2'b10:   apply_op = {even_parity(x), x};
         2'b11:   apply_op = {1'b0, a};
         default: apply_op = {(WIDTH+1){1'b0}};
      endcase
   endfunction

   logic [STAGES-1:0] v_r;
   logic [STAGES-1:0] p_r;
   logic [WIDTH-1:0]  c_r [STAGES];
   logic [15:0]       xfer_r;

   logic [STAGES-1:0] adv_s;
   logic [STAGES-1:0] load_s;
   logic [STAGES-1:0] pred_v_s;
   logic [STAGES-1:0] pred_p_s;
   logic [WIDTH-1:0]  pred_c_s [STAGES];
   logic [WIDTH:0]    entry_s;

   assign entry_s = apply_op(in_a, in_b, in_mode);

   // Advance chain: a stage may move on if the output is taken or any later stage is empty.
   always_comb begin
      logic hole_s;
      hole_s = 1'b0;
      adv_s  = {STAGES{1'b0}};
      for (int i = STAGES - 1; i >= 0; i--) begin
         adv_s[i] = out_ready | hole_s;
         hole_s   = hole_s | ~v_r[i];
      end
      load_s = ~v_r | adv_s;
   end

   // Predecessor of each stage: the computed entry word for stage 0, else the previous stage.
   always_comb begin
      pred_v_s = {STAGES{1'b0}};
      pred_p_s = {STAGES{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
         pred_c_s[i] = {WIDTH{1'b0}};
      end
      pred_v_s[0] = in_valid;
      pred_c_s[0] = entry_s[WIDTH-1:0];
      pred_p_s[0] = entry_s[WIDTH];
      for (int i = 1; i < STAGES; i++) begin
         pred_v_s[i] = v_r[i-1];
         pred_c_s[i] = c_r[i-1];
         pred_p_s[i] = p_r[i-1];
      end
   end

   // Stage registers: load from the predecessor whenever the stage is empty or advancing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_r <= {STAGES{1'b0}};
         p_r <= {STAGES{1'b0}};
         for (int i = 0; i < STAGES; i++) begin
            c_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (load_s[i]) begin
               v_r[i] <= pred_v_s[i];
               c_r[i] <= pred_c_s[i];
               p_r[i] <= pred_p_s[i];
            end else begin
               v_r[i] <= v_r[i];
               c_r[i] <= c_r[i];
               p_r[i] <= p_r[i];
            end
         end
      end
   end

   // Completed output handshakes, wrapping at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_r <= 16'd0;
      end else if (v_r[STAGES-1] && out_ready) begin
         xfer_r <= xfer_r + 16'd1;
      end else begin
         xfer_r <= xfer_r;
      end
   end

   assign in_ready   = load_s[0];
   assign out_valid  = v_r[STAGES-1];
   assign out_c      = c_r[STAGES-1];
   assign out_parity = p_r[STAGES-1];
   assign xfer_count = xfer_r;

endmodule
